// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sample width, complex sample payload and
// the bit-reversal helper used by the reorder stage and twiddle addressing.
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 16;
    localparam int unsigned FFT_MAX_LOG2N  = 16;
    localparam int unsigned FFT_IDX_W      = $clog2(FFT_MAX_LOG2N);

    typedef struct packed {
        logic signed [FFT_DATA_WIDTH-1:0] re;
        logic signed [FFT_DATA_WIDTH-1:0] im;
    } cplx_t;

    // Reverse the low log2n bits of index; upper bits of the result are zero.
    function automatic logic [FFT_MAX_LOG2N-1:0] bit_reverse(
        input logic [FFT_MAX_LOG2N-1:0] index,
        input int unsigned              log2n
    );
        logic [FFT_MAX_LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < FFT_MAX_LOG2N; i++) begin
            if (i < log2n) begin
                r[FFT_IDX_W'(log2n - 1 - i)] = index[FFT_IDX_W'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store addressed by {bank, index}.
// Ports: clk; i_wr_en/i_wr_bank/i_wr_addr/i_wr_data synchronous write port;
//        i_rd_bank/i_rd_addr select the word driven on o_rd_data_c (async read).
module fft_pingpong_ram #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic              i_wr_bank,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic              i_rd_bank,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data_c
);

    localparam int unsigned DEPTH = 2 * (2 ** ADDR_W);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[{i_wr_bank, i_wr_addr}] <= i_wr_data;
        end
    end

    // Read port feeds the output register in the parent directly
    assign o_rd_data_c = r_mem[{i_rd_bank, i_rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Reorders FFT frames from bit-reversed to natural order using a ping-pong
// buffer, so one frame can be written while the previous one drains.
// Ports: clk, rst (sync, active-high);
//        in_valid/in_ready/in_real/in_imag   bit-reversed input stream;
//        out_valid/out_ready/out_real/out_imag/out_last natural-order output.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FFT_DATA_WIDTH,
    parameter int unsigned N_POINTS   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_real,
    output logic signed [DATA_WIDTH-1:0] out_imag,
    output logic                         out_last
);

    localparam int unsigned LOG2N    = $clog2(N_POINTS);
    localparam int unsigned SAMPLE_W = 2 * DATA_WIDTH;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

    logic                  r_wbank;
    logic                  r_rbank;
    logic [LOG2N-1:0]      r_wcnt;
    logic [LOG2N-1:0]      r_rcnt;
    logic [1:0]            r_full;
    logic                  r_out_valid;
    logic                  r_out_last;
    logic [DATA_WIDTH-1:0] r_out_real;
    logic [DATA_WIDTH-1:0] r_out_imag;

    logic                  w_in_ready;
    logic                  w_wr_en;
    logic                  w_wr_last;
    logic [LOG2N-1:0]      w_wr_addr;
    logic                  w_load;
    logic                  w_rd_last;
    logic [SAMPLE_W-1:0]   w_rd_data;
    logic [1:0]            w_full_nxt;

    // Ready depends only on registered state, never on in_valid
    assign w_in_ready = !rst && !r_full[r_wbank];
    assign w_wr_en    = in_valid && w_in_ready;
    assign w_wr_last  = (r_wcnt == LAST_IDX);
    assign w_wr_addr  = LOG2N'(bit_reverse(FFT_MAX_LOG2N'(r_wcnt), LOG2N));

    assign w_load     = r_full[r_rbank] && (!r_out_valid || out_ready);
    assign w_rd_last  = (r_rcnt == LAST_IDX);

    fft_pingpong_ram #(
        .WIDTH  (SAMPLE_W),
        .ADDR_W (LOG2N)
    ) u_ram (
        .clk         (clk),
        .i_wr_en     (w_wr_en),
        .i_wr_bank   (r_wbank),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   ({in_real, in_imag}),
        .i_rd_bank   (r_rbank),
        .i_rd_addr   (r_rcnt),
        .o_rd_data_c (w_rd_data)
    );

    // Full flags: writer sets its bank, reader clears its bank; both may
    // happen in one cycle and never target the same bank simultaneously.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_en && w_wr_last) begin
            w_full_nxt[r_wbank] = 1'b1;
        end
        if (w_load && w_rd_last) begin
            w_full_nxt[r_rbank] = 1'b0;
        end
    end

    // Counters, bank pointers and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbank     <= 1'b0;
            r_rbank     <= 1'b0;
            r_wcnt      <= '0;
            r_rcnt      <= '0;
            r_full      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
        end else begin
            r_full <= w_full_nxt;

            if (w_wr_en) begin
                r_wcnt <= r_wcnt + LOG2N'(1);
                if (w_wr_last) begin
                    r_wbank <= !r_wbank;
                end
            end

            if (w_load) begin
                r_out_real  <= w_rd_data[SAMPLE_W-1:DATA_WIDTH];
                r_out_imag  <= w_rd_data[DATA_WIDTH-1:0];
                r_out_last  <= w_rd_last;
                r_out_valid <= 1'b1;
                r_rcnt      <= r_rcnt + LOG2N'(1);
                if (w_rd_last) begin
                    r_rbank <= !r_rbank;
                end
            end else if (out_ready && r_out_valid) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign out_real  = r_out_real;
    assign out_imag  = r_out_imag;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder with N_POINTS = 8.
module tb_fft_bitrev_reorder;
    import fft_pkg::*;

    localparam int unsigned DW = 16;
    localparam int unsigned NP = 8;

    typedef struct packed {
        cplx_t s;
        logic  last;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_real;
    logic signed [DW-1:0] in_imag;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_real;
    logic signed [DW-1:0] out_imag;
    logic                 out_last;

    exp_t sb[$];
    int   xfer_cycles[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_re, prev_im;
    logic          prev_last;

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int br3(input int j);
        return ((j & 1) << 2) | (j & 2) | ((j >> 2) & 1);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each output handshake, checks hold-stability
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_real !== prev_re || out_imag !== prev_im
                    || out_last !== prev_last) begin
                    n_err++;
                    $display("FAIL hold: got v=%b re=%h im=%h last=%b expected v=1 re=%h im=%h last=%b",
                             out_valid, out_real, out_imag, out_last, prev_re, prev_im, prev_last);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got re=%h im=%h last=%b expected none",
                             out_real, out_imag, out_last);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (out_real !== e.s.re || out_imag !== e.s.im || out_last !== e.last) begin
                        n_err++;
                        $display("FAIL sb_data: got re=%h im=%h last=%b expected re=%h im=%h last=%b",
                                 out_real, out_imag, out_last, e.s.re, e.s.im, e.last);
                    end
                end
                xfer_cycles.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = out_real;
            prev_im    = out_imag;
            prev_last  = out_last;
        end
    end

    task automatic send_sample(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int t;
        t        = 0;
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            t++;
            if (t > 2000) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 2000 cycles");
                break;
            end
        end
    endtask

    // Push natural-order expectations, then drive the frame in bit-reversed order
    task automatic send_frame(input cplx_t x [NP], input bit gaps);
        exp_t e;
        for (int k = 0; k < NP; k++) begin
            e.s    = x[k];
            e.last = (k == NP - 1);
            sb.push_back(e);
        end
        for (int j = 0; j < NP; j++) begin
            if (gaps) begin
                while ($urandom_range(0, 1) == 0) begin
                    in_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            send_sample(x[br3(j)].re, x[br3(j)].im);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(sb.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    cplx_t fr [NP];
    bit    done;
    int    t0;
    int    tw;
    bit    found;

    initial begin
        void'($urandom(32'd1234));
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_real   = '0;
        in_imag   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_last", 32'(out_last), 32'd0);
        @(posedge clk); #1;

        // Natural-order frame with latency check
        out_ready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            fr[k].re = 16'(k);
            fr[k].im = 16'(-k);
        end
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_first_valid", 32'(out_valid), 32'd1);
        wait_drain("natural_drain");

        // Four back-to-back frames, ready held high
        xfer_cycles.delete();
        t0 = cyc;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NP; k++) begin
                fr[k].re = 16'(100 * (f + 1) + k);
                fr[k].im = 16'(-(100 * (f + 1)) - k - 1);
            end
            send_frame(fr, 1'b0);
        end
        check("b2b_accept_cycles", 32'(cyc - t0), 32'd32);
        wait_drain("b2b_drain");
        check("b2b_out_count", 32'(xfer_cycles.size()), 32'd32);
        if (xfer_cycles.size() == 32)
            check("b2b_out_no_gaps", 32'(xfer_cycles[31] - xfer_cycles[0]), 32'd31);

        // Back-pressure: two frames buffered with no drain
        out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NP; k++) begin
                fr[k].re = 16'(16'h0A00 + 16 * f + k);
                fr[k].im = 16'(16'h0B00 + 16 * f + k);
            end
            send_frame(fr, 1'b0);
        end
        in_valid = 1'b1;
        in_real  = 16'h5555;
        in_imag  = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_17th_refused", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_x0_waiting", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after_pulse", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
                found = 1'b1;
                break;
            end
            check("bp_ready_still_low", 32'(in_ready), 32'd0);
        end
        check("bp_last_seen", 32'(found), 32'd1);
        check("bp_ready_rises", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        wait_drain("bp_drain");

        // Random stalls on both sides over ten frames
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 10; f++) begin
                    for (int k = 0; k < NP; k++) begin
                        fr[k].re = 16'($urandom);
                        fr[k].im = 16'($urandom);
                    end
                    send_frame(fr, 1'b1);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain("rand_drain");

        // Reset mid-frame: frame 0 stored, 5 samples of frame 1, 3 outputs taken
        out_ready = 1'b0;
        for (int k = 0; k < NP; k++) begin
            fr[k].re = 16'(16'h0C00 + k);
            fr[k].im = 16'(16'h0D00 + k);
        end
        send_frame(fr, 1'b0);
        for (int j = 0; j < 5; j++) send_sample(16'h0EEE, 16'h0FFF);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        check("mid_rst_out_real", 32'(out_real), 32'd0);
        check("mid_rst_out_imag", 32'(out_imag), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int k = 0; k < NP; k++) begin
            fr[k].re = 16'(16'h0100 + k);
            fr[k].im = 16'(16'h0200 - k);
        end
        send_frame(fr, 1'b0);
        wait_drain("after_rst_drain");

        // Signed extremes pass through bit-exact
        for (int k = 0; k < NP; k++) begin
            fr[k].re = (k % 2 == 0) ? 16'h8000 : 16'h7FFF;
            fr[k].im = (k % 2 == 0) ? 16'h7FFF : 16'h8000;
        end
        fr[3].re = 16'hFFFF;
        fr[6].im = 16'h0001;
        send_frame(fr, 1'b0);
        wait_drain("extremes_drain");

        tw = 0;
        repeat (10) @(negedge clk);
        check("final_idle_valid", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
